// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues memory requests, buffers one stalled word in a
// skid register, drains stale requests after a flush and flags ack timeouts.
module ifetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  output logic        hold_o,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_out_o,
  output logic        err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, FETCH, SKID, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          req_pending_q;
  logic [31:0]   addr_q;
  logic          valid_q;
  logic [31:0]   inst_q, pc_q;
  logic [31:0]   skid_inst_q, skid_pc_q;
  logic [CW-1:0] wait_cnt_q;
  logic          err_q;

  logic consume, waiting;
  logic load_mem, load_skid, to_skid;

  assign mem_req_o  = (state_q == FETCH) || (state_q == DRAIN);
  assign mem_addr_o = req_pending_q ? addr_q : pc_i;
  assign hold_o     = !(flush_i || ((state_q == FETCH) && mem_ack_i));
  assign consume    = valid_q && !stall_i;
  assign waiting    = mem_req_o && !mem_ack_i;

  assign valid_o  = valid_q;
  assign inst_o   = inst_q;
  assign pc_out_o = pc_q;
  assign err_o    = err_q;

  always_comb begin
    state_d   = state_q;
    load_mem  = 1'b0;
    load_skid = 1'b0;
    to_skid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = FETCH;
      end
      FETCH: begin
        if (flush_i) begin
          state_d = mem_ack_i ? FETCH : DRAIN;
        end else if (mem_ack_i) begin
          // A stalled, still-valid output forces the new word into the skid slot
          if (!valid_q || !stall_i) begin
            load_mem = 1'b1;
          end else begin
            to_skid = 1'b1;
            state_d = SKID;
          end
        end
      end
      SKID: begin
        if (flush_i) begin
          state_d = FETCH;
        end else if (!stall_i) begin
          load_skid = 1'b1;
          state_d   = FETCH;
        end
      end
      DRAIN: begin
        if (mem_ack_i) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      req_pending_q <= 1'b0;
      addr_q        <= '0;
      valid_q       <= 1'b0;
      inst_q        <= '0;
      pc_q          <= '0;
      skid_inst_q   <= '0;
      skid_pc_q     <= '0;
      wait_cnt_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;

      // Address is latched on the first request cycle and replayed until acked
      if (mem_req_o) begin
        req_pending_q <= !mem_ack_i;
        addr_q        <= mem_addr_o;
      end else begin
        req_pending_q <= 1'b0;
      end

      if (mem_req_o && mem_ack_i) begin
        wait_cnt_q <= '0;
      end else if (waiting && (wait_cnt_q != TMAX)) begin
        wait_cnt_q <= wait_cnt_q + CW'(1);
      end
      if (waiting && (wait_cnt_q == TMAX - CW'(1))) err_q <= 1'b1;

      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (load_mem) begin
        valid_q <= 1'b1;
        inst_q  <= mem_data_i;
        pc_q    <= mem_addr_o;
      end else if (load_skid) begin
        valid_q <= 1'b1;
        inst_q  <= skid_inst_q;
        pc_q    <= skid_pc_q;
      end else if (consume) begin
        valid_q <= 1'b0;
      end

      if (to_skid) begin
        skid_inst_q <= mem_data_i;
        skid_pc_q   <= mem_addr_o;
      end else if (flush_i) begin
        skid_inst_q <= '0;
        skid_pc_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Table-driven bench for ifetch_unit: one record per clock cycle, inputs applied
// after the rising edge and every output compared mid-cycle.
module tb_ifetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        hold_o;
  logic        flush_i;
  logic        stall_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_out_o;
  logic        err_o;

  int compared = 0;
  int mismatched = 0;

  ifetch_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .hold_o(hold_o), .flush_i(flush_i), .stall_i(stall_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .valid_o(valid_o), .inst_o(inst_o), .pc_out_o(pc_out_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst, st;
    logic [31:0] pc;
    logic        fl, stl, ack;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic        hold, valid;
    logic [31:0] inst, pcout;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic st, logic [31:0] pc, logic fl, logic stl,
                              logic ack, logic [31:0] data, logic req, logic [31:0] addr,
                              logic hold, logic valid, logic [31:0] inst,
                              logic [31:0] pcout, logic err);
    vec_t v;
    v.rst = rst; v.st = st; v.pc = pc; v.fl = fl; v.stl = stl; v.ack = ack; v.data = data;
    v.req = req; v.addr = addr; v.hold = hold; v.valid = valid; v.inst = inst;
    v.pcout = pcout; v.err = err;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_i = v.rst; start_i = v.st; pc_i = v.pc; flush_i = v.fl;
    stall_i = v.stl; mem_ack_i = v.ack; mem_data_i = v.data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic runRow(input string tag, input vec_t v);
    applyStimulus(v);
    @(negedge clk_i);
    checkOutput({tag, " mem_req"}, {31'd0, mem_req_o}, {31'd0, v.req});
    if (v.req) checkOutput({tag, " mem_addr"}, mem_addr_o, v.addr);
    checkOutput({tag, " hold"},  {31'd0, hold_o},  {31'd0, v.hold});
    checkOutput({tag, " valid"}, {31'd0, valid_o}, {31'd0, v.valid});
    checkOutput({tag, " inst"},  inst_o,  v.inst);
    checkOutput({tag, " pc_out"}, pc_out_o, v.pcout);
    checkOutput({tag, " err"},   {31'd0, err_o},   {31'd0, v.err});
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // rst st pc fl stl ack data | req addr hold valid inst pcout err
    tbl.push_back(mk(1,1,32'h0,  0,0,0,32'h0,  0,32'h0,  1,0,32'h0,  32'h0,  0)); // idle
    tbl.push_back(mk(1,0,32'h0,  0,0,1,32'h11, 1,32'h0,  0,0,32'h0,  32'h0,  0)); // single-cycle ack
    tbl.push_back(mk(1,0,32'h40, 0,0,0,32'h0,  1,32'h40, 1,1,32'h11, 32'h0,  0)); // wait 1
    tbl.push_back(mk(1,0,32'h44, 0,0,0,32'h0,  1,32'h40, 1,0,32'h11, 32'h0,  0)); // wait 2
    tbl.push_back(mk(1,0,32'h44, 0,0,0,32'h0,  1,32'h40, 1,0,32'h11, 32'h0,  0)); // wait 3
    tbl.push_back(mk(1,0,32'h44, 0,0,1,32'h33, 1,32'h40, 0,0,32'h11, 32'h0,  0)); // late ack
    tbl.push_back(mk(1,0,32'h44, 0,1,1,32'h22, 1,32'h44, 0,1,32'h33, 32'h40, 0)); // ack under stall
    tbl.push_back(mk(1,0,32'h48, 0,1,0,32'h0,  0,32'h0,  1,1,32'h33, 32'h40, 0)); // skid hold
    tbl.push_back(mk(1,0,32'h48, 0,0,0,32'h0,  0,32'h0,  1,1,32'h33, 32'h40, 0)); // skid release
    tbl.push_back(mk(1,0,32'h48, 0,0,1,32'h55, 1,32'h48, 0,1,32'h22, 32'h44, 0)); // back-to-back
    tbl.push_back(mk(1,0,32'h4C, 0,0,1,32'h66, 1,32'h4C, 0,1,32'h55, 32'h48, 0));
    tbl.push_back(mk(1,0,32'h80, 0,1,0,32'h0,  1,32'h80, 1,1,32'h66, 32'h4C, 0)); // req at 0x80
    tbl.push_back(mk(1,0,32'h200,1,1,0,32'h0,  1,32'h80, 0,1,32'h66, 32'h4C, 0)); // flush
    tbl.push_back(mk(1,0,32'h200,0,0,0,32'h0,  1,32'h80, 1,0,32'h66, 32'h4C, 0)); // drain
    tbl.push_back(mk(1,0,32'h200,0,0,1,32'h99, 1,32'h80, 1,0,32'h66, 32'h4C, 0)); // stale ack
    tbl.push_back(mk(1,0,32'h200,0,0,1,32'h77, 1,32'h200,0,0,32'h66, 32'h4C, 0)); // target fetch
    tbl.push_back(mk(1,0,32'h204,0,0,0,32'h0,  1,32'h204,1,1,32'h77, 32'h200,0)); // timeout wait 1
    tbl.push_back(mk(1,0,32'h204,0,0,0,32'h0,  1,32'h204,1,0,32'h77, 32'h200,0));
    tbl.push_back(mk(1,0,32'h204,0,0,0,32'h0,  1,32'h204,1,0,32'h77, 32'h200,0));
    tbl.push_back(mk(1,0,32'h204,0,0,0,32'h0,  1,32'h204,1,0,32'h77, 32'h200,0)); // wait 4
    tbl.push_back(mk(1,0,32'h204,0,0,0,32'h0,  1,32'h204,1,0,32'h77, 32'h200,1)); // err set
    tbl.push_back(mk(1,0,32'h204,0,0,1,32'hAA, 1,32'h204,0,0,32'h77, 32'h200,1)); // ack after timeout
    tbl.push_back(mk(1,0,32'h208,0,1,0,32'h0,  1,32'h208,1,1,32'hAA, 32'h204,1));

    rst_i = 1'b0; start_i = 1'b0; pc_i = '0; flush_i = 1'b0;
    stall_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;

    for (int i = 0; i < tbl.size(); i++) runRow($sformatf("row%0d", i), tbl[i]);

    // Reset while draining abandons the request; an ack landing in IDLE is ignored
    runRow("rstA", mk(1,0,32'h20C,1,0,0,32'h0,  1,32'h208,0,1,32'hAA,32'h204,1));
    runRow("rstB", mk(0,0,32'h20C,0,0,0,32'h0,  1,32'h208,1,0,32'hAA,32'h204,1));
    runRow("rstC", mk(1,0,32'h300,0,0,1,32'hCC, 0,32'h0,  1,0,32'h0, 32'h0,  0));
    runRow("rstD", mk(1,1,32'h300,0,0,0,32'h0,  0,32'h0,  1,0,32'h0, 32'h0,  0));
    runRow("rstE", mk(1,0,32'h300,0,0,1,32'hBB, 1,32'h300,0,0,32'h0, 32'h0,  0));
    runRow("rstF", mk(1,0,32'h304,0,1,0,32'h0,  1,32'h304,1,1,32'hBB,32'h300,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the ack-wait cycle count at which err_o sets.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 rst_i  in  1  reset, synchronous, active-low.
REQ-004 start_i  in  1  fetch enable; sampled only in IDLE.
REQ-005 pc_i  in  32  current PC from the PC register.
REQ-006 hold_o  out  1  to PC hold input; 1 freezes PC.
REQ-007 flush_i  in  1  branch/jump taken; discard in-flight and buffered fetches.
REQ-008 stall_i  in  1  decode stage not accepting this cycle.
REQ-009 mem_req_o  out  1  instruction memory request.
REQ-010 mem_addr_o  out  32  request address.
REQ-011 mem_ack_i  in  1  memory response valid; mem_data_i valid in same cycle.
REQ-012 mem_data_i  in  32  instruction word.
REQ-013 valid_o  out  1  inst_o/pc_out_o hold an unconsumed instruction.
REQ-014 inst_o  out  32  fetched instruction (IF/ID register).
REQ-015 pc_out_o  out  32  address of inst_o.
REQ-016 err_o  out  1  sticky memory-timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, SKID, DRAIN.
REQ-018 IDLE: mem_req_o=0, hold_o=1; start_i=1 -> FETCH next edge; no other exit besides reset.
REQ-019 FETCH/DRAIN: mem_req_o=1; SKID/IDLE: mem_req_o=0.
REQ-020 Once asserted, mem_req_o SHALL stay high with mem_addr_o stable until the cycle mem_ack_i=1 (flush and stall do not drop it).
REQ-021 mem_addr_o = pc_i on first request cycle; addr_q (pc_i latched that cycle) on later cycles of same request.
REQ-022 Consumption: instruction consumed on any edge with valid_o=1 and stall_i=0; valid_o clears then unless new data loads.
REQ-023 FETCH ack, no flush: if valid_o=0 or stall_i=0 -> inst_o<=mem_data_i, pc_out_o<=addr, valid_o<=1, stay FETCH; else -> skid<=data/addr, go SKID.
REQ-024 hold_o = 0 exactly when flush_i=1, or state FETCH with mem_ack_i=1; otherwise 1 (PC advances once per accepted fetch).
REQ-025 SKID: stall_i=0 -> output<=skid, valid_o=1, go FETCH; stall_i=1 -> hold all.
REQ-026 flush_i=1 (priority over stall_i and ack): valid_o<=0, skid discarded; if request outstanding with no ack this cycle -> DRAIN, else -> FETCH.
REQ-027 DRAIN: on ack discard data, go FETCH; hold_o=1 throughout; flush_i in DRAIN stays DRAIN.
REQ-028 Wait counter: counts cycles with mem_req_o=1 and mem_ack_i=0, clears on ack, saturates; reaching TIMEOUT_CYCLES sets err_o=1 until reset; FSM keeps waiting.
REQ-029 Back-to-back: ack every cycle with stall_i=0 SHALL give one instruction per cycle, no bubbles.

Reset
REQ-030 rst_i=0 at posedge: state IDLE, valid_o=0, inst_o=0, pc_out_o=0, skid cleared, err_o=0, counter=0; mem_req_o=0, hold_o=1 while in IDLE.
REQ-031 Reset mid-request SHALL abandon it without waiting for ack; ack arriving in IDLE ignored.

Verification
REQ-032 Reset, start_i=1, pc_i=0x0, single-cycle ack data 0x11 -> next edge inst_o=0x11, pc_out_o=0x0, valid_o=1, hold_o=0 in ack cycle.
REQ-033 pc_i=0x40, ack after 3 cycles -> mem_addr_o=0x40 and hold_o=1 for 3 cycles, hold_o=0 in ack cycle.
REQ-034 valid_o=1, stall_i=1, ack data 0x22 -> SKID, inst_o unchanged, mem_req_o=0; stall_i=0 -> inst_o=0x22 next edge.
REQ-035 Outstanding req at 0x80, flush_i=1 with pc_i=0x200 -> hold_o=0 that cycle, valid_o=0, DRAIN; ack discarded; next request addr 0x200.
REQ-036 TIMEOUT_CYCLES=4, no ack -> err_o=1 after 4 wait cycles, mem_req_o still 1; later ack completes normally, err_o stays 1.
REQ-037 Reset asserted during DRAIN -> IDLE, all outputs at reset values next edge.
